// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset/NOP defaults,
// fetch-stage state encoding and the IF/ID pipeline record.
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
        logic            misaligned;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages; clear beats hold, so a kill
// request squashes the slot even while the consumer is stalled.
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    input  logic   clear,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q.instr      <= NOP_INSTR;
            q.pc         <= '0;
            q.pc4        <= '0;
            q.valid      <= 1'b0;
            q.misaligned <= 1'b0;
        end else if (clear) begin
            q.instr      <= NOP_INSTR;
            q.pc         <= '0;
            q.pc4        <= '0;
            q.valid      <= 1'b0;
            q.misaligned <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses a combinational
// instruction memory and fills the IF/ID register for decode.
module if_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int              IM_AW     = 7
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] im_addr_o,
    input  logic [XLEN-1:0] im_data_i,
    output logic [XLEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_pc4_o,
    output logic            id_valid_o,
    output logic            id_misaligned_o,
    output logic [XLEN-1:0] fetch_count_o
);

    if_state_e       state_q;
    logic [XLEN-1:0] pc_q;
    logic            misalign_q;
    logic [XLEN-1:0] fetch_count_q;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_clear;
    logic            ifid_hold;
    logic            deliver;
    if_id_t          ifid_d;
    if_id_t          ifid_q;

    // Word index; the low IM_AW bits are what the memory decodes.
    assign im_addr_o = {2'b00, pc_q[XLEN-1:IM_AW+2], pc_q[IM_AW+1:2]};
    assign pc_plus4  = pc_q + 32'd4;

    // BOOT keeps the slot empty; kill requests win over a stall.
    assign ifid_clear = (state_q == BOOT) || flush_i || redirect_valid_i;
    assign ifid_hold  = stall_i;
    assign deliver    = !ifid_clear && !ifid_hold;

    always_comb begin
        ifid_d            = '0;
        ifid_d.instr      = im_data_i;
        ifid_d.pc         = pc_q;
        ifid_d.pc4        = pc_plus4;
        ifid_d.valid      = 1'b1;
        ifid_d.misaligned = misalign_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q <= RUN;
            if (redirect_valid_i) begin
                pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
                misalign_q <= |redirect_pc_i[1:0];
            end else if (state_q == RUN && !stall_i) begin
                pc_q       <= pc_plus4;
                misalign_q <= 1'b0;
            end
            if (deliver) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk  (clk_i),
        .rst  (rst_i),
        .hold (ifid_hold),
        .clear(ifid_clear),
        .d    (ifid_d),
        .q    (ifid_q)
    );

    assign id_instr_o      = ifid_q.instr;
    assign id_pc_o         = ifid_q.pc;
    assign id_pc4_o        = ifid_q.pc4;
    assign id_valid_o      = ifid_q.valid;
    assign id_misaligned_o = ifid_q.misaligned;
    assign fetch_count_o   = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, stall, flush, redirects,
// misaligned target, async reset and PC wrap against hand-derived values.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        id_misaligned;
    logic [31:0] fetch_count;

    int checks;
    int failures;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_i         (flush),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .im_addr_o       (im_addr),
        .im_data_i       (im_data),
        .id_instr_o      (id_instr),
        .id_pc_o         (id_pc),
        .id_pc4_o        (id_pc4),
        .id_valid_o      (id_valid),
        .id_misaligned_o (id_misaligned),
        .fetch_count_o   (fetch_count)
    );

    // Instruction memory: 128 words, word k is tagged with k.
    function automatic logic [31:0] mem_word(input logic [6:0] idx);
        return {16'hC0DE, 9'd0, idx};
    endfunction

    assign im_data = mem_word(im_addr[6:0]);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_instr"}, id_instr, NOP);
        check({tag, "_pc"}, id_pc, 32'd0);
        check({tag, "_pc4"}, id_pc4, 32'd0);
        check({tag, "_mis"}, {31'd0, id_misaligned}, 32'd0);
        check({tag, "_count"}, fetch_count, 32'd0);
        check({tag, "_addr"}, im_addr, 32'd0);
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc, input logic mis);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_pc4"}, id_pc4, pc + 32'd4);
        check({tag, "_instr"}, id_instr, mem_word(pc[8:2]));
        check({tag, "_mis"}, {31'd0, id_misaligned}, {31'd0, mis});
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({tag, "_instr"}, id_instr, NOP);
        check({tag, "_mis"}, {31'd0, id_misaligned}, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target, input logic with_stall);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        stall          = with_stall;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall          = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        step();
        step();
        check_reset_values("reset");

        // Boot: one bubble, then sequential delivery of words 0,1,2.
        rst = 1'b0;
        step();
        check_bubble("boot");
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        while (exp_q.size() > 0) begin
            step();
            check_slot("seq", exp_q.pop_front(), 1'b0);
        end
        check("seq_count", fetch_count, 32'd3);

        // Stall three cycles: IF/ID holds pc 0x8, PC holds at 0xC.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_slot("stall", 32'h8, 1'b0);
            check("stall_addr", im_addr, 32'd3);
            check("stall_count", fetch_count, 32'd3);
        end
        stall = 1'b0;
        step();
        check_slot("unstall", 32'hC, 1'b0);
        check("unstall_count", fetch_count, 32'd4);

        // Flush kills the instruction at 0x10; fetch continues at 0x14.
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_bubble("flush");
        step();
        check_slot("after_flush", 32'h14, 1'b0);
        check("flush_count", fetch_count, 32'd5);

        // Redirect to 0x40: bubble at N+1, target at N+2.
        redirect(32'h40, 1'b0);
        check_bubble("redir40_n1");
        check("redir40_addr", im_addr, 32'h10);
        step();
        check_slot("redir40_n2", 32'h40, 1'b0);
        check("redir40_count", fetch_count, 32'd6);

        // Redirect together with stall: redirect wins.
        redirect(32'h20, 1'b1);
        check_bubble("redir_stall_n1");
        step();
        check_slot("redir_stall_n2", 32'h20, 1'b0);
        check("redir_stall_count", fetch_count, 32'd7);

        // Misaligned target 0x42: aligned fetch flagged once.
        redirect(32'h42, 1'b0);
        check("mis_addr", im_addr, 32'h10);
        check_bubble("mis_n1");
        step();
        check_slot("mis_n2", 32'h40, 1'b1);
        step();
        check_slot("mis_next", 32'h44, 1'b0);
        check("mis_count", fetch_count, 32'd9);

        // Bring PC to 0x1C with a live slot, then reset asynchronously.
        redirect(32'h18, 1'b0);
        step();
        check_slot("pre_rst", 32'h18, 1'b0);
        check("pre_rst_addr", im_addr, 32'h7);
        check("pre_rst_count", fetch_count, 32'd10);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        check_reset_values("async_rst_hold");

        // Redirect during BOOT to the last word: PC wraps to 0.
        rst = 1'b0;
        redirect(32'hFFFF_FFFC, 1'b0);
        check_bubble("wrap_n1");
        check("wrap_addr", im_addr, 32'h3FFF_FFFF);
        step();
        check_slot("wrap_n2", 32'hFFFF_FFFC, 1'b0);
        check("wrap_pc4", id_pc4, 32'd0);
        step();
        check_slot("wrap_next", 32'h0, 1'b0);
        check("wrap_count", fetch_count, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
